// File: rtl/cart_rom_sequencer.sv
// Cartridge ROM sequencer: shares the ROM BRAM between download and CPU,
// sizes the image, detects SuperChip, and holds the console in reset.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   dl_active/dl_wr/dl_addr/dl_data   hps_io download stream
//   cpu_addr -> cpu_data              CPU cartridge fetch (1-cycle latency)
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port ROM BRAM
//   cpu_reset, ready                  console reset request / image ready
//   rom_size, sc_detect               image size and SuperChip flag
module cart_rom_sequencer #(
  parameter int AW          = 15,
  parameter int SCAN_LEN    = 256,
  parameter int HOLD_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          cpu_reset,
  output logic [AW+1:0] rom_size,
  output logic          sc_detect,
  output logic          ready
);

  typedef enum logic [1:0] {
    S_RUN, S_LOAD, S_SCAN, S_HOLD
  } state_t;

  localparam int SW = $clog2(SCAN_LEN + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW+1:0] SC_MIN   = (AW+2)'(8192);
  localparam logic [AW+1:0] SCAN_MIN = (AW+2)'(SCAN_LEN);
  localparam logic [SW-1:0] SCAN_END = SW'(SCAN_LEN);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic          dl_active_q;
  logic [SW-1:0] scan_q, scan_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW+1:0] rom_size_q, rom_size_d;
  logic          sc_q, sc_d;
  logic          match_q, match_d;
  logic [7:0]    ref_q, ref_d;

  logic          dl_rise;
  logic          in_range;
  logic          wr_ok;
  logic [AW+1:0] wr_size;

  assign dl_rise  = dl_active & ~dl_active_q;
  assign in_range = (dl_addr[24:AW] == '0);
  assign wr_ok    = (state_q == S_LOAD) & dl_wr & in_range;
  // Highest in-range address + 1 is at most 2^AW, so no explicit clamp.
  assign wr_size  = {2'b00, dl_addr[AW-1:0]} + (AW+2)'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      dl_active_q <= 1'b0;
      scan_q      <= '0;
      hold_q      <= '0;
      rom_size_q  <= '0;
      sc_q        <= 1'b0;
      match_q     <= 1'b0;
      ref_q       <= '0;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active;
      scan_q      <= scan_d;
      hold_q      <= hold_d;
      rom_size_q  <= rom_size_d;
      sc_q        <= sc_d;
      match_q     <= match_d;
      ref_q       <= ref_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    hold_d     = hold_q;
    rom_size_d = rom_size_q;
    sc_d       = sc_q;
    match_d    = match_q;
    ref_d      = ref_q;
    if (dl_rise) begin
      // A new download aborts whatever is in flight.
      state_d    = S_LOAD;
      rom_size_d = '0;
      sc_d       = 1'b0;
      scan_d     = '0;
      hold_d     = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (wr_ok && (wr_size > rom_size_q))
            rom_size_d = wr_size;
          if (!dl_active) begin
            state_d = S_SCAN;
            scan_d  = '0;
            match_d = 1'b1;
          end
        end
        S_SCAN: begin
          scan_d = scan_q + SW'(1);
          // rdata lags the issued address by one cycle
          if (scan_q == SW'(1))
            ref_d = mem_rdata;
          else if ((scan_q > SW'(1)) && (mem_rdata != ref_q))
            match_d = 1'b0;
          if (scan_q == SCAN_END) begin
            state_d = S_HOLD;
            hold_d  = '0;
            sc_d    = match_d
                    & (rom_size_q >= SC_MIN)
                    & (rom_size_q >= SCAN_MIN);
          end
        end
        S_HOLD: begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HOLD_END) begin
            state_d = S_RUN;
            hold_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = dl_data;
    cpu_data  = 8'hFF;
    cpu_reset = 1'b1;
    ready     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        cpu_data  = mem_rdata;
        cpu_reset = 1'b0;
        ready     = 1'b1;
      end
      S_LOAD: begin
        mem_addr = dl_addr[AW-1:0];
        mem_we   = wr_ok;
      end
      S_SCAN: mem_addr = AW'(scan_q);
      default: ;
    endcase
  end

  assign rom_size  = rom_size_q;
  assign sc_detect = sc_q;

endmodule

// File: tb/tb_cart_rom_sequencer.sv
// Directed bench for cart_rom_sequencer with a behavioural ROM BRAM.
// Inputs change on negedge; outputs sampled #1 after posedge or mid-cycle.
module tb_cart_rom_sequencer;

  localparam int AW = 15;
  localparam int LAT = 256 + 1 + 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_active, dl_wr;
  logic [24:0]   dl_addr;
  logic [7:0]    dl_data;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          cpu_reset;
  logic [AW+1:0] rom_size;
  logic          sc_detect;
  logic          ready;

  logic [7:0] rom [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) rom[mem_addr] <= mem_wdata;
    mem_rdata <= rom[mem_addr];
  end

  cart_rom_sequencer #(.AW(AW), .SCAN_LEN(256), .HOLD_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_reset(cpu_reset), .rom_size(rom_size),
    .sc_detect(sc_detect), .ready(ready)
  );

  task automatic dl_start();
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    @(negedge clk);
    dl_wr   = 1'b0;
  endtask

  // Drop dl_active at a negedge; return edges from the fall-sampling
  // edge to the edge after which cpu_reset is low.
  task automatic finish_load(output int lat);
    int n;
    dl_active = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cpu_reset && n < 2000);
    lat = n - 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dl_active = 0; dl_wr = 0;
    dl_addr = '0; dl_data = '0; cpu_addr = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || cpu_reset !== 1'b0 || rom_size !== '0) begin
      n_bad++;
      $display("FAIL por got rdy=%b rst=%b size=%0d exp 1 0 0",
               ready, cpu_reset, rom_size);
    end
    reset_n = 1'b1;
    dl_start();
    for (int i = 0; i < 8; i++) wr_byte(25'(i), 8'(i));
    n_cmp++;
    if (rom_size !== 17'd8 || cpu_reset !== 1'b1 || ready !== 1'b0
        || cpu_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL load_state got size=%0d rst=%b rdy=%b d=%h exp 8 1 0 ff",
               rom_size, cpu_reset, ready, cpu_data);
    end
    dl_wr = 1'b1; dl_addr = 25'h10;
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cpu_reset !== 1'b0 || ready !== 1'b1 || rom_size !== '0
        || mem_we !== 1'b0 || sc_detect !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst got rst=%b rdy=%b size=%0d we=%b sc=%b exp 0 1 0 0 0",
               cpu_reset, ready, rom_size, mem_we, sc_detect);
    end
    dl_wr = 0; dl_active = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_4k();
    int lat;
    dl_start();
    for (int i = 0; i < 4096; i++) wr_byte(25'(i), 8'(i));
    finish_load(lat);
    n_cmp++;
    if (lat != LAT) begin
      n_bad++;
      $display("FAIL 4k_latency got %0d exp %0d", lat, LAT);
    end
    n_cmp++;
    if (rom_size !== 17'd4096 || sc_detect !== 1'b0) begin
      n_bad++;
      $display("FAIL 4k_result got size=%0d sc=%b exp 4096 0",
               rom_size, sc_detect);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL 4k_ready got %b exp 1", ready);
    end
    @(negedge clk);
    cpu_addr = 15'h0123;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cpu_data !== 8'h23) begin
      n_bad++;
      $display("FAIL cpu_read got %h exp 23", cpu_data);
    end
    @(negedge clk);
    cpu_addr = 15'h0FFE;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cpu_data !== 8'hFE) begin
      n_bad++;
      $display("FAIL cpu_read2 got %h exp fe", cpu_data);
    end
  endtask

  task automatic test_superchip(input logic poke, input logic exp_sc);
    int lat;
    logic [7:0] d;
    dl_start();
    for (int i = 0; i < 16384; i++) begin
      d = (i < 256) ? 8'hFF : (8'(i) ^ 8'h5A);
      if (poke && i == 200) d = 8'h00;
      wr_byte(25'(i), d);
    end
    finish_load(lat);
    n_cmp++;
    if (rom_size !== 17'd16384 || sc_detect !== exp_sc) begin
      n_bad++;
      $display("FAIL superchip%0d got size=%0d sc=%b exp 16384 %b",
               poke, rom_size, sc_detect, exp_sc);
    end
  endtask

  task automatic test_small();
    int lat;
    dl_start();
    for (int i = 0; i < 255; i++) wr_byte(25'(i), 8'hFF);
    // last byte written in the same cycle dl_active falls
    dl_active = 1'b0;
    wr_byte(25'd255, 8'hFF);
    finish_load(lat);
    n_cmp++;
    if (rom_size !== 17'd256 || sc_detect !== 1'b0) begin
      n_bad++;
      $display("FAIL small got size=%0d sc=%b exp 256 0",
               rom_size, sc_detect);
    end
  endtask

  task automatic test_addr_range();
    int lat;
    dl_start();
    dl_wr = 1'b1; dl_addr = 25'h8000; dl_data = 8'hAA;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_8000 got we=%b exp 0", mem_we);
    end
    @(negedge clk);
    dl_addr = 25'h1FFFFFF;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_max got we=%b exp 0", mem_we);
    end
    @(negedge clk);
    dl_wr = 1'b0;
    n_cmp++;
    if (rom_size !== '0) begin
      n_bad++;
      $display("FAIL oob_size got %0d exp 0", rom_size);
    end
    dl_wr = 1'b1; dl_addr = 25'h0FFF; dl_data = 8'h5C;
    #1;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'h0FFF || mem_wdata !== 8'h5C) begin
      n_bad++;
      $display("FAIL wr_port got we=%b a=%h d=%h exp 1 0fff 5c",
               mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    wr_byte(25'h0010, 8'h11);
    n_cmp++;
    if (rom_size !== 17'h1000) begin
      n_bad++;
      $display("FAIL ooo_size got %h exp 1000", rom_size);
    end
    finish_load(lat);
    n_cmp++;
    if (rom_size !== 17'h1000 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ooo_final got size=%h rdy=%b exp 1000 1",
               rom_size, ready);
    end
  endtask

  task automatic test_abort_scan();
    int lat;
    int glitch;
    dl_start();
    for (int i = 0; i < 512; i++) wr_byte(25'(i), 8'hFF);
    dl_active = 1'b0;
    glitch = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (cpu_reset !== 1'b1 || ready !== 1'b0) glitch++;
    end
    @(negedge clk);
    dl_active = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rom_size !== '0 || cpu_reset !== 1'b1 || cpu_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL abort_entry got size=%0d rst=%b d=%h exp 0 1 ff",
               rom_size, cpu_reset, cpu_data);
    end
    repeat (300) begin
      @(posedge clk);
      #1;
      if (cpu_reset !== 1'b1 || ready !== 1'b0) glitch++;
    end
    n_cmp++;
    if (glitch != 0) begin
      n_bad++;
      $display("FAIL abort_glitch got %0d bad cycles exp 0", glitch);
    end
    @(negedge clk);
    for (int i = 0; i < 300; i++) wr_byte(25'(i), 8'(i));
    finish_load(lat);
    n_cmp++;
    if (rom_size !== 17'd300 || lat != LAT) begin
      n_bad++;
      $display("FAIL abort_reload got size=%0d lat=%0d exp 300 %0d",
               rom_size, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_load_4k();
    test_superchip(1'b0, 1'b1);
    test_superchip(1'b1, 1'b0);
    test_small();
    test_addr_range();
    test_abort_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
